fifo_word_unpacker: RTL and testbench

//  Read-side companion of the multi-lane word-width FIFO. Pops one wide word
//  (NUM_FIFOS lanes of WIDTH bits) from the FIFO read port and streams it out
//  one lane per beat on a valid/ready interface, flagging the last lane.

---
 rtl/fifo_word_unpacker.sv | 135 +++++++++++++
 tb/tb_fifo_word_unpacker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_unpacker.sv
// Read side of the multi-lane word FIFO: pops one wide word and streams its
// lanes one per beat on a valid/ready interface, marking the final lane.
module fifo_word_unpacker #(
  parameter int NUM_FIFOS = 2,
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                       read_clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_read_en,
  input  logic [NUM_FIFOS*WIDTH-1:0] fifo_data,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [CNT_W-1:0]           words_done
);

  localparam int IDX_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIFOS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_FIFOS*WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]           data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       last_q, last_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       pop_req;

  // Map a beat index to its lane, honouring the configured send order.
  function automatic logic [WIDTH-1:0] lane_sel(input logic [NUM_FIFOS*WIDTH-1:0] word,
                                                input logic [IDX_W-1:0]           idx);
    logic [IDX_W-1:0] pos;
    if (LSB_FIRST) begin
      pos = idx;
    end else begin
      pos = LAST_IDX - idx;
    end
    return word[pos*WIDTH +: WIDTH];
  endfunction

  // Next-state, datapath and pop-request logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pop_req = 1'b0;
    case (state_q)
      IDLE: begin
        pop_req = ~fifo_empty;
        if (!fifo_empty) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Read data arrives one cycle after the pop; preload the first lane.
        word_d  = fifo_data;
        idx_d   = {IDX_W{1'b0}};
        data_d  = lane_sel(fifo_data, {IDX_W{1'b0}});
        last_d  = 1'b0;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = cnt_q + 1'b1;
            valid_d = 1'b0;
            pop_req = ~fifo_empty;
            if (!fifo_empty) begin
              state_d = WAIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = lane_sel(word_q, idx_q + 1'b1);
            last_d = ((idx_q + 1'b1) == LAST_IDX);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= {(NUM_FIFOS*WIDTH){1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_read_en = pop_req & ~rst;
  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign busy         = (state_q != IDLE);
  assign words_done   = cnt_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Scoreboard bench: two unpackers (LSB-first/16-bit count, MSB-first/2-bit count)
// share one modelled FIFO; a monitor checks every accepted beat and the counters.
module tb_fifo_word_unpacker;

  localparam int N = 2;
  localparam int W = 8;

  logic        read_clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        out_ready = 1'b0;
  logic [15:0] fifo_data = 16'h0000;
  logic        rd_a, rd_b, ov_a, ov_b, ol_a, ol_b, busy_a, busy_b;
  logic [7:0]  od_a, od_b;
  logic [15:0] wd_a;
  logic [1:0]  wd_b;

  always #5 read_clk = ~read_clk;

  fifo_word_unpacker #(.NUM_FIFOS(N), .WIDTH(W), .LSB_FIRST(1'b1), .CNT_W(16)) dut_a (
    .read_clk(read_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_en(rd_a),
    .fifo_data(fifo_data), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_last(ol_a), .busy(busy_a), .words_done(wd_a));

  fifo_word_unpacker #(.NUM_FIFOS(N), .WIDTH(W), .LSB_FIRST(1'b0), .CNT_W(2)) dut_b (
    .read_clk(read_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_en(rd_b),
    .fifo_data(fifo_data), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_last(ol_b), .busy(busy_b), .words_done(wd_b));

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t       sb_a[$];
  beat_t       sb_b[$];
  logic [15:0] fq[$];
  int          checks = 0;
  int          errors = 0;
  int          mcnt = 0;
  logic        force_empty = 1'b0;
  logic        last_pop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    logic [15:0] w;
    logic        p;
    logic        ok;
    fifo_empty = force_empty || (fq.size() == 0);
    #1;
    p = rd_a;
    chk("read_en_match", {31'd0, rd_b}, {31'd0, rd_a});
    w = 16'h0000;
    if (p) begin
      chk("pop_when_empty", {31'd0, fifo_empty}, 32'd0);
      ok = (sb_a.size() == 0) ||
           (sb_a.size() == 1 && sb_a[0].last && ov_a && out_ready);
      chk("pop_word_pending", {31'd0, ok}, 32'd1);
      if (fq.size() > 0) w = fq.pop_front();
      for (int k = 0; k < N; k++) begin
        sb_a.push_back('{data: 8'((w >> (8 * k)) % 256), last: (k == N - 1)});
        sb_b.push_back('{data: 8'((w >> (8 * (N - 1 - k))) % 256), last: (k == N - 1)});
      end
    end
    last_pop = p;
    @(negedge read_clk);
    if (p) fifo_data = w;
  endtask

  // Monitor: judges the handshake that the coming rising edge will complete.
  initial begin
    beat_t e;
    forever begin
      @(negedge read_clk);
      #2;
      chk("words_done_a", {16'd0, wd_a}, 32'(mcnt % 65536));
      chk("words_done_b", {30'd0, wd_b}, 32'(mcnt % 4));
      if (rst) begin
        sb_a.delete();
        sb_b.delete();
        mcnt = 0;
      end else begin
        chk("valid_match", {31'd0, ov_b}, {31'd0, ov_a});
        if (ov_a && out_ready) begin
          if (sb_a.size() == 0 || sb_b.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = sb_a.pop_front();
            chk("data_a", {24'd0, od_a}, {24'd0, e.data});
            chk("last_a", {31'd0, ol_a}, {31'd0, e.last});
            if (e.last) mcnt++;
            e = sb_b.pop_front();
            chk("data_b", {24'd0, od_b}, {24'd0, e.data});
            chk("last_b", {31'd0, ol_b}, {31'd0, e.last});
          end
        end
      end
    end
  end

  initial begin
    int   beats;
    int   pops;
    logic seen;
    @(negedge read_clk);
    fq.push_back(16'h1111);
    tick();
    tick();
    chk("rst_read_en", {31'd0, last_pop}, 32'd0);
    chk("rst_valid", {31'd0, ov_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_words", {16'd0, wd_a}, 32'd0);
    chk("rst_data", {24'd0, od_a}, 32'd0);
    fq.delete();
    rst = 1'b0;

    // Single word, both lane orders.
    fq.push_back(16'hA55A);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = last_pop;
    end
    chk("single_pop_seen", {31'd0, seen}, 32'd1);
    chk("single_wait_valid", {31'd0, ov_a}, 32'd0);
    tick();
    chk("lat2_valid", {31'd0, ov_a}, 32'd1);
    chk("lsb_beat0", {23'd0, ol_a, od_a}, {23'd0, 1'b0, 8'h5A});
    chk("msb_beat0", {23'd0, ol_b, od_b}, {23'd0, 1'b0, 8'hA5});
    tick();
    chk("lsb_beat1", {23'd0, ol_a, od_a}, {23'd0, 1'b1, 8'hA5});
    chk("msb_beat1", {23'd0, ol_b, od_b}, {23'd0, 1'b1, 8'h5A});
    tick();
    chk("single_done_valid", {31'd0, ov_a}, 32'd0);
    chk("single_words", {16'd0, wd_a}, 32'd1);
    chk("single_idle", {31'd0, busy_a}, 32'd0);
    chk("data_held_idle", {24'd0, od_a}, 32'h000000A5);

    // Backpressure on lane 0 with a second word waiting in the FIFO.
    out_ready = 1'b0;
    fq.push_back(16'hA55A);
    fq.push_back(16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = last_pop;
    end
    chk("bp_pop_seen", {31'd0, seen}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {22'd0, ov_a, ol_a, od_a}, {22'd0, 1'b1, 1'b0, 8'h5A});
      tick();
      chk("bp_no_pop", {31'd0, last_pop}, 32'd0);
    end
    chk("bp_hold_end", {24'd0, od_a}, 32'h0000005A);
    out_ready = 1'b1;
    tick();
    chk("bp_resume", {23'd0, ol_a, od_a}, {23'd0, 1'b1, 8'hA5});
    tick();
    chk("bp_pop_on_last", {31'd0, last_pop}, 32'd1);
    chk("bp_wait_valid", {31'd0, ov_a}, 32'd0);
    repeat (3) tick();
    chk("bp_words", {16'd0, wd_a}, 32'd3);
    chk("bp_idle", {31'd0, busy_a}, 32'd0);

    // Back-to-back words with the consumer always ready.
    for (int i = 0; i < 3; i++) fq.push_back(16'($urandom));
    pops = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !ov_a; i++) begin
      tick();
      pops += int'(last_pop);
    end
    chk("b2b_first_valid", {31'd0, ov_a}, 32'd1);
    beats = 0;
    for (int i = 0; i < 9; i++) begin
      if (ov_a && out_ready) beats++;
      if (wd_a == 16'd5 && !seen) begin
        chk("wrap_cnt2_at5", {30'd0, wd_b}, 32'd1);
        seen = 1'b1;
      end
      tick();
      pops += int'(last_pop);
    end
    chk("b2b_beats", beats, 32'd6);
    chk("b2b_pops", pops, 32'd3);
    chk("b2b_words", {16'd0, wd_a}, 32'd6);
    chk("b2b_wrap_seen", {31'd0, seen}, 32'd1);
    chk("b2b_wrap_6", {30'd0, wd_b}, 32'd2);

    // Empty FIFO must never be popped.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_no_pop", {31'd0, last_pop}, 32'd0);
    end

    // Reset while the final lane is on the output.
    fq.push_back(16'hBEEF);
    for (int i = 0; i < 10 && !(ov_a && ol_a); i++) tick();
    chk("midrst_on_lane1", {31'd0, ov_a && ol_a}, 32'd1);
    rst = 1'b1;
    fq.delete();
    tick();
    rst = 1'b0;
    chk("midrst_idle", {31'd0, busy_a}, 32'd0);
    chk("midrst_valid", {31'd0, ov_a}, 32'd0);
    chk("midrst_words", {16'd0, wd_a}, 32'd0);

    // Randomised traffic, backpressure, empty flag and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) fq.push_back(16'($urandom));
      rst = ($urandom_range(0, 299) == 0);
      if (rst) fq.delete();
      tick();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    force_empty = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = (fq.size() == 0) && !busy_a && (sb_a.size() == 0);
    end
    chk("drain_complete", {31'd0, seen}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
